// File: rtl/picorv32_bus_dma.sv
// Word-copy DMA engine for the PicoRV32 native memory bus.
// Software programs SRC/DST/LEN through a responder-side register window and
// writes START. The engine then alternates one bus read and one bus write per
// word, leaving one idle cycle between requests.
module picorv32_bus_dma #(
    parameter int unsigned LEN_W = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cfg_sel_i,
    input  logic [1:0]  cfg_addr_i,
    input  logic [3:0]  cfg_wstrb_i,
    input  logic [31:0] cfg_wdata_i,
    output logic [31:0] cfg_rdata_o,
    output logic        cfg_ready_o,
    output logic        m_valid_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_wstrb_o,
    input  logic        m_ready_i,
    input  logic [31:0] m_rdata_i,
    output logic        done_irq_o
);

    typedef enum logic [2:0] {StIdle, StRd, StGapW, StWr, StGapR} state_e;

    state_e           state_q;
    logic [31:0]      src_q, dst_q, cur_src_q, cur_dst_q, buf_q;
    logic [LEN_W-1:0] len_q, rem_q;
    logic             done_q, aborted_q, abort_pend_q;
    logic             cfg_ready_q, done_irq_q, m_valid_q;
    logic [31:0]      cfg_rdata_q, m_addr_q, m_wdata_q;
    logic [3:0]       m_wstrb_q;

    logic             busy, cfg_wr, start_cmd, abort_cmd, abort_now;
    logic [31:0]      base, wr_val, rd_val;

    // Register window decode: byte-merged write value, read mux and CTRL commands.
    always_comb begin
        busy = (state_q != StIdle);
        cfg_wr = cfg_sel_i && cfg_ready_q && (cfg_wstrb_i != 4'h0);
        case (cfg_addr_i)
            2'd0:    base = src_q;
            2'd1:    base = dst_q;
            2'd2:    base = 32'(len_q);
            default: base = 32'h0;
        endcase
        wr_val = base;
        for (int b = 0; b < 4; b++) begin
            if (cfg_wstrb_i[b]) wr_val[8*b +: 8] = cfg_wdata_i[8*b +: 8];
        end
        case (cfg_addr_i)
            2'd0:    rd_val = src_q;
            2'd1:    rd_val = dst_q;
            2'd2:    rd_val = 32'(len_q);
            default: rd_val = {28'h0, aborted_q, 1'b0, done_q, busy};
        endcase
        start_cmd = cfg_wr && (cfg_addr_i == 2'd3) && cfg_wstrb_i[0] && cfg_wdata_i[0] && !busy;
        abort_cmd = cfg_wr && (cfg_addr_i == 2'd3) && cfg_wstrb_i[0] && cfg_wdata_i[2] && busy;
        // An abort committed on a handshake edge takes effect on that same edge.
        abort_now = abort_pend_q || abort_cmd;
    end

    // Register window, job control and master FSM with registered bus outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StIdle;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            cur_src_q    <= '0;
            cur_dst_q    <= '0;
            rem_q        <= '0;
            buf_q        <= '0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            cfg_ready_q  <= 1'b0;
            cfg_rdata_q  <= '0;
            done_irq_q   <= 1'b0;
            m_valid_q    <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_wstrb_q    <= '0;
        end else begin
            cfg_ready_q <= cfg_sel_i && !cfg_ready_q;
            cfg_rdata_q <= (cfg_sel_i && !cfg_ready_q) ? rd_val : 32'h0;
            done_irq_q  <= 1'b0;

            if (cfg_wr && !busy) begin
                case (cfg_addr_i)
                    2'd0:    src_q <= {wr_val[31:2], 2'b00};
                    2'd1:    dst_q <= {wr_val[31:2], 2'b00};
                    2'd2:    len_q <= wr_val[LEN_W-1:0];
                    default: ;
                endcase
            end

            if (abort_cmd) abort_pend_q <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    abort_pend_q <= 1'b0;
                    if (start_cmd) begin
                        aborted_q <= 1'b0;
                        if (len_q == '0) begin
                            done_q     <= 1'b1;
                            done_irq_q <= 1'b1;
                        end else begin
                            done_q    <= 1'b0;
                            cur_src_q <= src_q;
                            cur_dst_q <= dst_q;
                            rem_q     <= len_q;
                            m_valid_q <= 1'b1;
                            m_addr_q  <= src_q;
                            m_wstrb_q <= 4'h0;
                            state_q   <= StRd;
                        end
                    end
                end
                StRd: begin
                    if (m_ready_i) begin
                        buf_q     <= m_rdata_i;
                        m_valid_q <= 1'b0;
                        if (abort_now) begin
                            aborted_q <= 1'b1;
                            state_q   <= StIdle;
                        end else begin
                            state_q <= StGapW;
                        end
                    end
                end
                StGapW: begin
                    if (abort_now) begin
                        aborted_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        m_valid_q <= 1'b1;
                        m_addr_q  <= cur_dst_q;
                        m_wdata_q <= buf_q;
                        m_wstrb_q <= 4'hF;
                        state_q   <= StWr;
                    end
                end
                StWr: begin
                    if (m_ready_i) begin
                        m_valid_q <= 1'b0;
                        m_wstrb_q <= 4'h0;
                        cur_src_q <= cur_src_q + 32'd4;
                        cur_dst_q <= cur_dst_q + 32'd4;
                        rem_q     <= rem_q - LEN_W'(1);
                        if (abort_now) begin
                            aborted_q <= 1'b1;
                            state_q   <= StIdle;
                        end else if (rem_q == LEN_W'(1)) begin
                            done_q     <= 1'b1;
                            done_irq_q <= 1'b1;
                            state_q    <= StIdle;
                        end else begin
                            state_q <= StGapR;
                        end
                    end
                end
                StGapR: begin
                    if (abort_now) begin
                        aborted_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        m_valid_q <= 1'b1;
                        m_addr_q  <= cur_src_q;
                        m_wstrb_q <= 4'h0;
                        state_q   <= StRd;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cfg_rdata_o = cfg_rdata_q;
    assign cfg_ready_o = cfg_ready_q;
    assign m_valid_o   = m_valid_q;
    assign m_addr_o    = m_addr_q;
    assign m_wdata_o   = m_wdata_q;
    assign m_wstrb_o   = m_wstrb_q;
    assign done_irq_o  = done_irq_q;

endmodule

// File: doc/picorv32_bus_dma.md
Name: picorv32_bus_dma

Overview:
- Word-copy DMA engine and the second initiator on the PicoRV32 native memory bus (valid/ready, addr, wdata, wstrb, rdata).
- Software programs it through a small responder-side register window. It then issues read/write transactions as a bus master, so any existing responder (ROM, RAM, GPIO) can be the source or destination.
- Arbitration with the CPU is outside this block.

Parameters:
LEN_W, 16, width of the transfer word-count register (max LEN_W-bit words per job)

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
cfg_sel  input  1  register window selected (responder side, held until cfg_ready)
cfg_addr  input  2  register index: 0 SRC, 1 DST, 2 LEN, 3 CTRL/STATUS
cfg_wstrb  input  4  byte write strobes; 0 = read
cfg_wdata  input  32  register write data
cfg_rdata  output  32  register read data, valid while cfg_ready
cfg_ready  output  1  responder handshake
m_valid  output  1  master request
m_addr  output  32  master address, word aligned
m_wdata  output  32  master write data
m_wstrb  output  4  master strobes; 0 = read, 4'hF = write
m_ready  input  1  responder handshake
m_rdata  input  32  read data, valid when m_ready
done_irq  output  1  one-cycle completion pulse

Behaviour:
Reset and outputs
- Every output resets to 0 on the first clk edge with resetn=0.
- All registers, counters and status bits reset to 0; state returns to IDLE.
- Reset mid-job drops m_valid at that edge; no further transactions are issued.

Register window (responder side)
- cfg_ready <= cfg_sel && !cfg_ready. This gives one cycle latency and a one-cycle pulse per access.
- Register writes commit on the edge where cfg_sel && cfg_ready; each strobe gates its own byte.
- SRC/DST bits [1:0] read back 0 and are ignored.
- LEN uses bits [LEN_W-1:0]; upper bits read 0.
- CTRL write bits:
  - bit0 START, effective only when not busy.
  - bit2 ABORT, effective only when busy.
- STATUS read bits:
  - bit0 BUSY
  - bit1 DONE (sticky)
  - bit3 ABORTED (sticky)
  - other bits 0
- While BUSY, writes to SRC/DST/LEN are ignored, and START is ignored.
- START clears DONE and ABORTED.
- Reads of SRC/DST/LEN return programmed values, not the running counters.
- cfg_rdata is 0 when cfg_ready is low.

Master state machine: IDLE, RD, GAP_W, WR, GAP_R
- IDLE, START accepted:
  - If LEN=0: DONE=1 and done_irq pulse on the next cycle; no bus traffic.
  - Else: load cur_src, cur_dst and remaining from SRC/DST/LEN; BUSY=1; go to RD.
  - m_valid rises the cycle after the commit edge.
- RD: m_valid=1, m_addr=cur_src, m_wstrb=0. On an edge with m_ready: buf<=m_rdata, go to GAP_W.
- GAP_W: m_valid=0 for exactly one cycle, then go to WR.
- WR: m_valid=1, m_addr=cur_dst, m_wdata=buf, m_wstrb=4'hF. On an edge with m_ready:
  - cur_src+=4, cur_dst+=4, remaining-=1.
  - If remaining was 1 or abort is pending: go to IDLE.
  - Else: go to GAP_R.
- GAP_R: m_valid=0 for one cycle, then go to RD.
- Bus protocol: m_addr/m_wdata/m_wstrb stay stable, and m_valid never drops, while a request is waiting for m_ready. Unlimited wait states are tolerated.
- Address arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- Normal completion (entry to IDLE after the last WR handshake):
  - BUSY=0, DONE=1, done_irq=1 for that one cycle.
- ABORT:
  - Sets abort-pending. The outstanding request, if any, runs to its handshake.
  - A pending RD is followed by neither GAP_W nor WR.
  - Result: go to IDLE, BUSY=0, ABORTED=1, DONE stays 0, no done_irq.
  - If ABORT arrives in a GAP state, the engine goes to IDLE at the next edge.
- A START written in the same cycle as completion is ignored (BUSY is still 1 at the commit edge).
- Throughput: 6 cycles per word with 1-cycle-latency responders.

Test Plan:
- Copy 3 words: SRC=0x4000, DST=0x5000, LEN=3, responder returns 0x11,0x22,0x33 -> reads at 0x4000/4004/4008 and writes 0x11/0x22/0x33 to 0x5000/5004/5008 in order; done_irq 1 cycle; STATUS=0x2; 18 bus cycles.
- Wait states: responder inserts 4 stall cycles per access, LEN=2 -> m_addr/m_wdata stable throughout each stall; m_valid never drops before m_ready; same data result.
- LEN=0 START -> no m_valid ever; DONE=1 and done_irq one cycle after the commit edge.
- Abort during second RD of LEN=5 -> that read completes, no write follows; total 1 write; STATUS=0x8; no done_irq.
- Wrap and alignment: SRC=0xFFFF_FFFE, DST=0x100, LEN=2 -> reads at 0xFFFF_FFFC then 0x0000_0000; SRC reads back 0xFFFF_FFFC.
- Busy protection and reset: write DST=0x9999 and START while busy -> ignored, DST unchanged. Then assert resetn=0 mid-WR -> m_valid=0 and STATUS=0 at the next edge.
